gas_alarm_controller: RTL and testbench
=======================================

# gas_alarm_controller

Consumes the 3-bit event vector from the gas detector sensor stage and turns it into household alarm actions: buzzer, ventilation fan and an alarm level for the home controller. Event pulses are registered, then escalated by a Moore state machine. Repeated low-level events are rate-qualified inside a time window. The machine holds the critical alarm until a user acknowledge, then runs the ventilation for a fixed purge period.

## Interface
- LOW_THRESH, 3 — number of low-level events within the window that escalates to WARN (≥2)
- WIN_LEN, 64 — low-event window length, cycles
- QUIET_LEN, 128 — event-free cycles that drop WARN back to IDLE
- HOLD_LEN, 32 — ventilation purge cycles after acknowledge
- BEEP_HALF, 4 — buzzer half-period in WARN, cycles
- clk  in  1  clock, rising edge
- arst  in  1  reset: one clock; reset is asynchronous and active-low (arst low clears everything)
- det  in  3  detector events, 1-cycle pulses. [2] critical, [1] medium, [0] low. Any combination is legal.
- ack  in  1  user acknowledge, level, sampled on clk
- level  out  2  0 IDLE, 1 WARN, 2 ALARM, 3 HOLD
- buzzer  out  1  buzzer drive
- vent_on  out  1  ventilation fan drive
- crit_cnt  out  8  critical events since reset, saturating

## Operation
- Input stage: det_q <= det every edge. Downstream logic uses det_q only, which removes glitches from the combinational detector output.
- Priority when several det_q bits are set: [2] > [1] > [0]. All counters still update for every set bit.
- crit_cnt: +1 on each cycle with det_q[2] = 1, in any state. Saturates at 255.
- Low-event qualifier: low_cnt (4 bits) and win_tmr (16 bits).
  - When det_q[0] arrives with low_cnt = 0: low_cnt becomes 1 and win_tmr becomes 0.
  - While low_cnt ≠ 0, win_tmr increments each cycle.
  - When win_tmr = WIN_LEN-1 and there is no det_q[0] that cycle, low_cnt is cleared.
  - When det_q[0] arrives with low_cnt = LOW_THRESH-1, the qualifier raises low_hit and low_cnt is cleared.
  - low_cnt is cleared on every state change.
- States (Moore outputs):
  - IDLE: level=0, buzzer=0, vent_on=0.
    - det_q[2] → ALARM
    - det_q[1] or low_hit → WARN
  - WARN: level=1, vent_on=1.
    - buzzer starts at 1 on entry and toggles every BEEP_HALF cycles.
    - quiet_tmr is cleared on entry and on any det_q[1:0] event.
    - det_q[2] → ALARM
    - ack → IDLE
    - quiet_tmr = QUIET_LEN-1 → IDLE
  - ALARM: level=2, buzzer=1, vent_on=1.
    - ack with det_q[2] = 0 → HOLD.
    - ack together with det_q[2] stays in ALARM.
  - HOLD: level=3, buzzer=0, vent_on=1.
    - hold_tmr is cleared on entry.
    - det_q[2] → ALARM (restart)
    - hold_tmr = HOLD_LEN-1 → IDLE
- All timers are 16 bits. Parameters must fit in 16 bits. Timers never wrap, because the state exits at the terminal count.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE.
  - level=0, buzzer=0, vent_on=0, crit_cnt=0.
  - det_q, low_cnt and all timers = 0.
- Latency: a det pulse sampled at edge k appears in det_q after edge k. The state and outputs change after edge k+1 (2 edges total).
- crit_cnt updates after edge k+1.
- ack is sampled directly, so the exit from ALARM occurs at the first edge where ack = 1.
- Residency:
  - HOLD lasts exactly HOLD_LEN cycles.
  - WARN exits after QUIET_LEN event-free cycles.
- Buzzer in WARN: a period of 2·BEEP_HALF cycles, with phase reset on every entry to WARN.
- ack held high across states has no effect in IDLE or HOLD.

## Test plan
- Critical event and acknowledge:
  - Reset, then det=3'b100 for 1 cycle → level=2, buzzer=1, vent_on=1 after 2 edges, and crit_cnt=1.
  - ack for 1 cycle → level=3, buzzer=0 for 32 cycles, then level=0 and vent_on=0.
- Low-event escalation: three det=3'b001 pulses spaced 10 cycles apart → level=1 two edges after the third pulse. buzzer then shows 1111 0000 repeating. 128 idle cycles → level=0.
- Window expiry: two det=001 pulses, a 70-cycle gap, then one pulse → level stays 0. Two further pulses 5 cycles apart → level=1.
- Simultaneous events: det=3'b111 in IDLE → ALARM and crit_cnt=1. In ALARM, assert ack together with a det=100 pulse in det_q → stays at level 2. ack on the next cycle → HOLD. A det=100 pulse during HOLD cycle 10 → back to level 2.
- Saturation and reset: 300 det=100 pulses → crit_cnt=255. Drop arst mid-ALARM → all outputs 0 immediately, without waiting for a clock edge. Release arst → level=0.

Source files
------------

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: registers detector events, rate-qualifies low-level events
// and escalates through IDLE/WARN/ALARM/HOLD with buzzer and ventilation drive.
module gas_alarm_controller #(
  parameter int unsigned LOW_THRESH = 3,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned QUIET_LEN  = 128,
  parameter int unsigned HOLD_LEN   = 32,
  parameter int unsigned BEEP_HALF  = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] det,
  input  logic       ack,
  output logic [1:0] level,
  output logic       buzzer,
  output logic       vent_on,
  output logic [7:0] crit_cnt
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned LOW_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [TMR_W-1:0] WIN_LAST   = TMR_W'(WIN_LEN - 1);
  localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'(QUIET_LEN - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_LEN - 1);
  localparam logic [TMR_W-1:0] BEEP_LAST  = TMR_W'(BEEP_HALF - 1);
  localparam logic [LOW_W-1:0] LOW_LAST   = LOW_W'(LOW_THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       det_q;
  logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
  logic [TMR_W-1:0] win_tmr_q, win_tmr_d;
  logic [TMR_W-1:0] quiet_tmr_q, quiet_tmr_d;
  logic [TMR_W-1:0] hold_tmr_q, hold_tmr_d;
  logic [TMR_W-1:0] beep_tmr_q, beep_tmr_d;
  logic [CNT_W-1:0] crit_cnt_q, crit_cnt_d;
  logic [1:0]       level_q, level_d;
  logic             buzzer_q, buzzer_d;
  logic             vent_q, vent_d;
  logic             low_hit;
  logic             warn_evt;

  assign low_hit  = det_q[0] && (low_cnt_q == LOW_LAST);
  assign warn_evt = |det_q[1:0];

  // Next-state logic; a det_q[1:0] event in WARN takes precedence over quiet expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (det_q[2])                 state_d = ST_ALARM;
        else if (det_q[1] || low_hit) state_d = ST_WARN;
      end
      ST_WARN: begin
        if (det_q[2])                                   state_d = ST_ALARM;
        else if (ack)                                   state_d = ST_IDLE;
        else if (!warn_evt && quiet_tmr_q >= QUIET_LAST) state_d = ST_IDLE;
      end
      ST_ALARM: begin
        if (ack && !det_q[2]) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (det_q[2])                     state_d = ST_ALARM;
        else if (hold_tmr_q >= HOLD_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state
  always_comb begin
    level_d  = 2'(state_d);
    vent_d   = (state_d != ST_IDLE);
    buzzer_d = 1'b0;
    case (state_d)
      ST_ALARM: buzzer_d = 1'b1;
      ST_WARN: begin
        if (state_q != ST_WARN)          buzzer_d = 1'b1;
        else if (beep_tmr_q == BEEP_LAST) buzzer_d = ~buzzer_q;
        else                              buzzer_d = buzzer_q;
      end
      default: buzzer_d = 1'b0;
    endcase
  end

  // Residency timers restart on every entry and read zero outside their state
  always_comb begin
    quiet_tmr_d = '0;
    hold_tmr_d  = '0;
    beep_tmr_d  = '0;
    if (state_q == ST_WARN && state_d == ST_WARN) begin
      if (!warn_evt) quiet_tmr_d = quiet_tmr_q + TMR_W'(1);
      if (beep_tmr_q != BEEP_LAST) beep_tmr_d = beep_tmr_q + TMR_W'(1);
    end
    if (state_q == ST_HOLD && state_d == ST_HOLD) hold_tmr_d = hold_tmr_q + TMR_W'(1);
  end

  // Low-event qualifier: window opens on the first low event, expires at WIN_LEN
  always_comb begin
    low_cnt_d = low_cnt_q;
    win_tmr_d = win_tmr_q;
    if (low_cnt_q != '0 && win_tmr_q != '1) win_tmr_d = win_tmr_q + TMR_W'(1);
    if (det_q[0]) begin
      if (low_cnt_q == '0) begin
        low_cnt_d = LOW_W'(1);
        win_tmr_d = '0;
      end else if (low_hit) begin
        low_cnt_d = '0;
      end else begin
        low_cnt_d = low_cnt_q + LOW_W'(1);
      end
    end else if (low_cnt_q != '0 && win_tmr_q >= WIN_LAST) begin
      low_cnt_d = '0;
    end
    if (state_d != state_q) low_cnt_d = '0;
  end

  always_comb begin
    crit_cnt_d = crit_cnt_q;
    if (det_q[2] && crit_cnt_q != CNT_MAX) crit_cnt_d = crit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= ST_IDLE;
      det_q       <= '0;
      low_cnt_q   <= '0;
      win_tmr_q   <= '0;
      quiet_tmr_q <= '0;
      hold_tmr_q  <= '0;
      beep_tmr_q  <= '0;
      crit_cnt_q  <= '0;
      level_q     <= '0;
      buzzer_q    <= 1'b0;
      vent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det;
      low_cnt_q   <= low_cnt_d;
      win_tmr_q   <= win_tmr_d;
      quiet_tmr_q <= quiet_tmr_d;
      hold_tmr_q  <= hold_tmr_d;
      beep_tmr_q  <= beep_tmr_d;
      crit_cnt_q  <= crit_cnt_d;
      level_q     <= level_d;
      buzzer_q    <= buzzer_d;
      vent_q      <= vent_d;
    end
  end

  assign level    = level_q;
  assign buzzer   = buzzer_q;
  assign vent_on  = vent_q;
  assign crit_cnt = crit_cnt_q;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Bench for gas_alarm_controller: time-stamp based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_gas_alarm_controller;

  localparam int LT = 3;
  localparam int WL = 64;
  localparam int QL = 128;
  localparam int HL = 32;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic [2:0] det;
  logic       ack;
  logic [1:0] level;
  logic       buzzer;
  logic       vent_on;
  logic [7:0] crit_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  gas_alarm_controller #(
    .LOW_THRESH(LT), .WIN_LEN(WL), .QUIET_LEN(QL), .HOLD_LEN(HL), .BEEP_HALF(BH)
  ) dut (
    .clk(clk), .arst(arst), .det(det), .ack(ack),
    .level(level), .buzzer(buzzer), .vent_on(vent_on), .crit_cnt(crit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode plus time stamps of the events that govern each exit
  int         n;
  int         m_st;
  logic [2:0] m_dq;
  int         m_crit, m_lcnt, m_wstart, m_last_evt, m_hold_start, m_warn_start;
  int         m_nst;
  bit         m_hit;

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      n = 0; m_st = 0; m_dq = 3'b000; m_crit = 0; m_lcnt = 0; m_wstart = 0;
      m_last_evt = 0; m_hold_start = 0; m_warn_start = 0;
    end else begin
      n++;
      if (m_dq[2] && m_crit < 255) m_crit++;
      m_hit = m_dq[0] && (m_lcnt == LT - 1);
      m_nst = m_st;
      case (m_st)
        0: if (m_dq[2]) m_nst = 2; else if (m_dq[1] || m_hit) m_nst = 1;
        1: begin
          if (m_dq[2]) m_nst = 2;
          else if (ack) m_nst = 0;
          else if (m_dq[1:0] != 2'b00) m_last_evt = n;
          else if (n - m_last_evt >= QL) m_nst = 0;
        end
        2: if (ack && !m_dq[2]) m_nst = 3;
        default: if (m_dq[2]) m_nst = 2; else if (n - m_hold_start >= HL) m_nst = 0;
      endcase
      if (m_dq[0]) begin
        if (m_lcnt == 0) begin m_lcnt = 1; m_wstart = n; end
        else if (m_hit) m_lcnt = 0;
        else m_lcnt++;
      end else if (m_lcnt != 0 && n - m_wstart >= WL) m_lcnt = 0;
      if (m_nst != m_st) begin
        m_lcnt = 0;
        if (m_nst == 1) begin m_warn_start = n; m_last_evt = n; end
        if (m_nst == 3) m_hold_start = n;
      end
      m_st = m_nst;
      m_dq = det;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_level", 32'(level), 32'(m_st));
      chk("cyc_vent", 32'(vent_on), 32'(m_st != 0));
      chk("cyc_buzzer", 32'(buzzer),
          32'((m_st == 2) || (m_st == 1 && ((n - m_warn_start) / BH) % 2 == 0)));
      chk("cyc_crit", 32'(crit_cnt), 32'(m_crit));
    end
  end

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #2; end
  endtask

  task automatic pulse(input logic [2:0] v);
    det = v; step(1); det = 3'b000;
  endtask

  task automatic do_reset();
    arst = 1'b0; det = 3'b000; ack = 1'b0;
    step(2);
    arst = 1'b1;
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 want 1 (run did not complete)");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b0; det = 3'b000; ack = 1'b0;
    step(2);
    chk_en = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_vent", 32'(vent_on), 0);
    chk("rst_crit", 32'(crit_cnt), 0);
    arst = 1'b1;
    step(2);

    // Critical event, acknowledge, purge
    pulse(3'b100); step(1);
    chk("crit_level", 32'(level), 2);
    chk("crit_buzzer", 32'(buzzer), 1);
    chk("crit_vent", 32'(vent_on), 1);
    chk("crit_cnt1", 32'(crit_cnt), 1);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("hold_level", 32'(level), 3);
    chk("hold_buzzer", 32'(buzzer), 0);
    step(HL - 1);
    chk("hold_last", 32'(level), 3);
    step(1);
    chk("hold_exit_level", 32'(level), 0);
    chk("hold_exit_vent", 32'(vent_on), 0);

    // Low-event escalation, beep pattern, quiet exit
    pulse(3'b001); step(9); pulse(3'b001); step(9); pulse(3'b001); step(1);
    chk("low_warn", 32'(level), 1);
    chk("low_beep0", 32'(buzzer), 1);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("low_beep", 32'(buzzer), 32'(((i / BH) % 2) == 0));
    end
    step(QL - 16);
    chk("quiet_last", 32'(level), 1);
    step(1);
    chk("quiet_exit", 32'(level), 0);

    // Window expiry then re-qualification
    pulse(3'b001); step(9); pulse(3'b001); step(70); pulse(3'b001); step(1);
    chk("win_expired", 32'(level), 0);
    step(3); pulse(3'b001); step(4); pulse(3'b001); step(1);
    chk("win_requal", 32'(level), 1);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("warn_ack", 32'(level), 0);

    // Medium event enters WARN; a later low event restarts the quiet period
    pulse(3'b010); step(1);
    chk("med_warn", 32'(level), 1);
    step(50); pulse(3'b001); step(QL);
    chk("med_quiet_hold", 32'(level), 1);
    step(1);
    chk("med_quiet_exit", 32'(level), 0);

    // Simultaneous events, ack blocked by critical, HOLD restart
    do_reset();
    pulse(3'b111); step(1);
    chk("sim_level", 32'(level), 2);
    chk("sim_crit", 32'(crit_cnt), 1);
    det = 3'b100; step(1); det = 3'b000;
    ack = 1'b1; step(1);
    chk("ack_blocked", 32'(level), 2);
    chk("ack_blk_crit", 32'(crit_cnt), 2);
    step(1);
    chk("ack_hold", 32'(level), 3);
    step(9); ack = 1'b0;
    chk("hold_ack_ignored", 32'(level), 3);
    pulse(3'b100); step(1);
    chk("hold_restart", 32'(level), 2);
    chk("hold_restart_crit", 32'(crit_cnt), 3);

    // Saturation, then asynchronous reset mid-ALARM
    repeat (300) begin det = 3'b100; step(1); end
    det = 3'b000; step(1);
    chk("sat_crit", 32'(crit_cnt), 255);
    chk("sat_level", 32'(level), 2);
    @(posedge clk); #3;
    arst = 1'b0; #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_buzzer", 32'(buzzer), 0);
    chk("arst_vent", 32'(vent_on), 0);
    chk("arst_crit", 32'(crit_cnt), 0);
    step(2);
    arst = 1'b1;
    step(2);
    chk("post_rst_level", 32'(level), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
